mem_access_load_unit: RTL and testbench
=======================================

Name: mem_access_load_unit

Overview:
- MemAccess-stage load engine that consumes the single load handed over per cycle by the load/store unit.
- Issues each load to the data cache, waits for the response, then aligns and sign/zero-extends the returned word.
- Produces one registered writeback record per load (destination PRF, ROB tag, data or misalign fault) for the commit/broadcast path.
- Single outstanding load; squashes in-flight work on a pipeline flush.

Parameters:
- XLEN, 32, data/address width.
- ROB_TAG_W, 5, ROB tag width.
- PRF_W, 6, physical register index width.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset; synchronous, active-low, sampled on rising clk.
- flush  input  1  pipeline flush (store-set violation or ROB redirect); kills all in-flight work.
- lsu_valid  input  1  load packet valid from LSU.
- lsu_ready  output  1  unit can accept a packet this cycle.
- lsu_addr  input  XLEN  effective address.
- lsu_size  input  2  0=byte, 1=half, 2=word; 3 is illegal and is treated as word.
- lsu_unsigned  input  1  zero-extend when 1, sign-extend when 0.
- lsu_rob_tag  input  ROB_TAG_W  ROB tag of the load.
- lsu_prd  input  PRF_W  destination physical register.
- dc_req  output  1  D-cache read request.
- dc_addr  output  XLEN  word-aligned request address ({addr[XLEN-1:2],2'b00}).
- dc_gnt  input  1  cache accepted the request this cycle.
- dc_rsp_valid  input  1  read data valid.
- dc_rsp_data  input  XLEN  read word.
- wb_valid  output  1  writeback record valid (one-cycle pulse).
- wb_rob_tag  output  ROB_TAG_W  tag of the completing load.
- wb_prd  output  PRF_W  destination register.
- wb_data  output  XLEN  aligned, extended data; faulting address when wb_misalign=1.
- wb_misalign  output  1  load address misaligned exception.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DRAIN.
- Reset (rst_n=0 at a clk edge): state=IDLE, all captured fields=0, dc_req=0, dc_addr=0, wb_valid=0, wb_misalign=0, wb_data=0, wb_rob_tag=0, wb_prd=0.
  - Applies in any state, including mid-WAIT; a later dc_rsp_valid is then ignored because state is IDLE.
- lsu_ready = (state==IDLE) && !flush, combinational.
- Accept occurs when lsu_valid && lsu_ready; the packet is captured at the clk edge.
- Misalign check at accept:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Misaligned load: no cache access; next cycle wb_valid=1, wb_misalign=1, wb_data=lsu_addr; state stays IDLE.
- Aligned load: state -> REQ.
  - In REQ, dc_req=1 and dc_addr stays stable until dc_gnt=1.
  - On grant -> WAIT.
- WAIT: on dc_rsp_valid, form the result and go to IDLE.
  - Shifted value = dc_rsp_data >> (8*addr[1:0]).
  - Byte: bits[7:0] extended. Half: bits[15:0] extended. Word: unchanged.
  - wb_valid=1 the following cycle with wb_misalign=0.
- Minimum latency from accept to wb_valid: 3 cycles (accept edge, REQ with immediate grant, WAIT with same-cycle response). Each extra wait cycle adds 1.
- wb_valid is a single-cycle pulse; the wb_* fields hold their last values when wb_valid=0.
- Flush handling:
  - IDLE: no accept; any pending misalign writeback scheduled for the next cycle is suppressed.
  - REQ without dc_gnt in the same cycle: -> IDLE, dc_req drops the next cycle.
  - REQ with dc_gnt, or WAIT without dc_rsp_valid: -> DRAIN.
  - WAIT with dc_rsp_valid in the same cycle: response is discarded, no wb_valid, -> IDLE.
  - DRAIN: lsu_ready=0; wait for dc_rsp_valid, discard it, -> IDLE. A further flush in DRAIN has no additional effect.
- flush has priority over a simultaneous lsu_valid and over writeback generation.
- dc_rsp_valid while in IDLE or REQ is ignored (protocol error; no output change).

Test Plan:
- Aligned word load: addr=0x1000, size=2, rsp data=0xDEADBEEF, grant and response immediate -> wb_valid 3 cycles after accept, wb_data=0xDEADBEEF, wb_misalign=0, rob_tag/prd echoed.
- Signed byte vs unsigned half: addr=0x1003 byte signed, rsp 0x80FF_0000 -> wb_data=0xFFFFFF80. Addr=0x1002 half unsigned, same rsp -> wb_data=0x000080FF.
- Misaligned word load at 0x1002 -> wb_valid next cycle, wb_misalign=1, wb_data=0x00001002, dc_req never asserted.
- Grant stall: dc_gnt held low 4 cycles -> dc_req/dc_addr stable throughout, lsu_ready=0, wb_valid exactly once after the response.
- Flush in WAIT with response 2 cycles later -> state DRAIN, no wb_valid, lsu_ready=1 the cycle after the discarded response. Flush coincident with the response -> no wb_valid, IDLE the next cycle.
- Reset mid-WAIT (rst_n low 1 cycle), then a stray dc_rsp_valid -> all outputs 0, no wb_valid, lsu_ready=1.

Source files
------------

// File: rtl/mem_access_load_unit_if.sv
// Load-unit bus bundle: LSU packet in, D-cache request/response, writeback record out.
interface mem_access_load_unit_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_TAG_W = 5,
    parameter int unsigned PRF_W     = 6
);
    logic                 flush;

    logic                 lsu_valid;
    logic                 lsu_ready;
    logic [XLEN-1:0]      lsu_addr;
    logic [1:0]           lsu_size;
    logic                 lsu_unsigned;
    logic [ROB_TAG_W-1:0] lsu_rob_tag;
    logic [PRF_W-1:0]     lsu_prd;

    logic                 dc_req;
    logic [XLEN-1:0]      dc_addr;
    logic                 dc_gnt;
    logic                 dc_rsp_valid;
    logic [XLEN-1:0]      dc_rsp_data;

    logic                 wb_valid;
    logic [ROB_TAG_W-1:0] wb_rob_tag;
    logic [PRF_W-1:0]     wb_prd;
    logic [XLEN-1:0]      wb_data;
    logic                 wb_misalign;

    // Pipeline / cache side: drives packets, grants and responses
    modport master (
        output flush,
        output lsu_valid, lsu_addr, lsu_size, lsu_unsigned, lsu_rob_tag, lsu_prd,
        output dc_gnt, dc_rsp_valid, dc_rsp_data,
        input  lsu_ready, dc_req, dc_addr,
        input  wb_valid, wb_rob_tag, wb_prd, wb_data, wb_misalign
    );

    // Load unit side
    modport slave (
        input  flush,
        input  lsu_valid, lsu_addr, lsu_size, lsu_unsigned, lsu_rob_tag, lsu_prd,
        input  dc_gnt, dc_rsp_valid, dc_rsp_data,
        output lsu_ready, dc_req, dc_addr,
        output wb_valid, wb_rob_tag, wb_prd, wb_data, wb_misalign
    );
endinterface

// File: rtl/mem_access_load_unit.sv
// MemAccess-stage load engine: one outstanding load, cache access, align/extend, writeback.
module mem_access_load_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ROB_TAG_W = 5,
    parameter int unsigned PRF_W     = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_access_load_unit_if.slave  bus
);
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;

    logic [OFF_W-1:0]       off_q;
    logic [SIZE_W-1:0]      size_q;
    logic                   uns_q;
    logic [ROB_TAG_W-1:0]   tag_q;
    logic [PRF_W-1:0]       prd_q;

    logic                   dc_req_q,      dc_req_d;
    logic [XLEN-1:0]        dc_addr_q,     dc_addr_d;
    logic                   wb_valid_q,    wb_valid_d;
    logic                   wb_misalign_q, wb_misalign_d;
    logic [XLEN-1:0]        wb_data_q,     wb_data_d;
    logic [ROB_TAG_W-1:0]   wb_tag_q,      wb_tag_d;
    logic [PRF_W-1:0]       wb_prd_q,      wb_prd_d;

    logic                   lsu_ready_c;
    logic                   accept_c;
    logic                   misalign_c;
    logic                   capture_c;
    logic [XLEN-1:0]        shifted_c;
    logic [XLEN-1:0]        load_data_c;

    // Only one load in flight; a flush closes the door for the current cycle
    assign lsu_ready_c = (state_q == IDLE) && !bus.flush;
    assign accept_c    = bus.lsu_valid && lsu_ready_c;

    // Natural-alignment check on the incoming packet (size 3 behaves as word)
    always_comb begin
        misalign_c = 1'b0;
        case (bus.lsu_size)
            2'd0:    misalign_c = 1'b0;
            2'd1:    misalign_c = bus.lsu_addr[0];
            default: misalign_c = (bus.lsu_addr[1:0] != 2'b00);
        endcase
    end

    // Byte-lane alignment and sign/zero extension of the returned word
    always_comb begin
        shifted_c   = bus.dc_rsp_data >> {off_q, 3'b000};
        load_data_c = shifted_c;
        case (size_q)
            2'd0: load_data_c = uns_q ? {{(XLEN-8){1'b0}}, shifted_c[7:0]}
                                      : {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            2'd1: load_data_c = uns_q ? {{(XLEN-16){1'b0}}, shifted_c[15:0]}
                                      : {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            default: load_data_c = shifted_c;
        endcase
    end

    // Next-state and registered-output decode; flush outranks accept and writeback
    always_comb begin
        state_d       = state_q;
        capture_c     = 1'b0;
        dc_addr_d     = dc_addr_q;
        wb_valid_d    = 1'b0;
        wb_misalign_d = wb_misalign_q;
        wb_data_d     = wb_data_q;
        wb_tag_d      = wb_tag_q;
        wb_prd_d      = wb_prd_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    capture_c = 1'b1;
                    if (misalign_c) begin
                        wb_valid_d    = 1'b1;
                        wb_misalign_d = 1'b1;
                        wb_data_d     = bus.lsu_addr;
                        wb_tag_d      = bus.lsu_rob_tag;
                        wb_prd_d      = bus.lsu_prd;
                    end else begin
                        state_d   = REQ;
                        dc_addr_d = {bus.lsu_addr[XLEN-1:2], 2'b00};
                    end
                end
            end
            REQ: begin
                if (bus.flush) begin
                    state_d = bus.dc_gnt ? DRAIN : IDLE;
                end else if (bus.dc_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = bus.dc_rsp_valid ? IDLE : DRAIN;
                end else if (bus.dc_rsp_valid) begin
                    state_d       = IDLE;
                    wb_valid_d    = 1'b1;
                    wb_misalign_d = 1'b0;
                    wb_data_d     = load_data_c;
                    wb_tag_d      = tag_q;
                    wb_prd_d      = prd_q;
                end
            end
            DRAIN: begin
                if (bus.dc_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        dc_req_d = (state_d == REQ);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dc_req_q      <= 1'b0;
            dc_addr_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_misalign_q <= 1'b0;
            wb_data_q     <= '0;
            wb_tag_q      <= '0;
            wb_prd_q      <= '0;
        end else begin
            state_q       <= state_d;
            dc_req_q      <= dc_req_d;
            dc_addr_q     <= dc_addr_d;
            wb_valid_q    <= wb_valid_d;
            wb_misalign_q <= wb_misalign_d;
            wb_data_q     <= wb_data_d;
            wb_tag_q      <= wb_tag_d;
            wb_prd_q      <= wb_prd_d;
        end
    end

    // Packet fields needed after the accept cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
            tag_q  <= '0;
            prd_q  <= '0;
        end else if (capture_c) begin
            off_q  <= bus.lsu_addr[1:0];
            size_q <= bus.lsu_size;
            uns_q  <= bus.lsu_unsigned;
            tag_q  <= bus.lsu_rob_tag;
            prd_q  <= bus.lsu_prd;
        end
    end

    assign bus.lsu_ready   = lsu_ready_c;
    assign bus.dc_req      = dc_req_q;
    assign bus.dc_addr     = dc_addr_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_misalign = wb_misalign_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rob_tag  = wb_tag_q;
    assign bus.wb_prd      = wb_prd_q;

endmodule

// File: tb/tb_mem_access_load_unit.sv
// Directed and randomized load traffic checked against a behavioural load model.
module tb_mem_access_load_unit;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;
    logic [31:0] last_wb_data;

    mem_access_load_unit_if #(.XLEN(32), .ROB_TAG_W(5), .PRF_W(6)) bus ();

    mem_access_load_unit #(.XLEN(32), .ROB_TAG_W(5), .PRF_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed bytes arithmetically, then extend by value range
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (addr % 4));
        if (size == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic bit ref_misalign(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    task automatic present(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [4:0] tag, input logic [5:0] prd);
        bus.lsu_valid    = 1'b1;
        bus.lsu_addr     = addr;
        bus.lsu_size     = size;
        bus.lsu_unsigned = uns;
        bus.lsu_rob_tag  = tag;
        bus.lsu_prd      = prd;
    endtask

    // Full load transaction; starts and ends just after a rising edge
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [4:0] tag, input logic [5:0] prd, input logic [31:0] word,
                           input int gnt_dly, input int rsp_dly);
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        bit          mis;
        mis      = ref_misalign(addr, size);
        exp_data = mis ? addr : ref_load(addr, size, uns, word);
        exp_addr = addr - (addr % 4);

        present(addr, size, uns, tag, prd);
        @(negedge clk);
        chk("accept_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        bus.lsu_valid = 1'b0;

        if (!mis) begin
            for (int i = 0; i < gnt_dly; i++) begin
                @(negedge clk);
                chk("stall_req", 32'(bus.dc_req), 32'd1);
                chk("stall_addr", bus.dc_addr, exp_addr);
                chk("stall_ready", 32'(bus.lsu_ready), 32'd0);
                chk("stall_wb", 32'(bus.wb_valid), 32'd0);
                tick();
            end
            bus.dc_gnt = 1'b1;
            @(negedge clk);
            chk("gnt_req", 32'(bus.dc_req), 32'd1);
            chk("gnt_addr", bus.dc_addr, exp_addr);
            tick();
            bus.dc_gnt = 1'b0;
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                chk("wait_req", 32'(bus.dc_req), 32'd0);
                chk("wait_wb", 32'(bus.wb_valid), 32'd0);
                chk("wait_ready", 32'(bus.lsu_ready), 32'd0);
                tick();
            end
            bus.dc_rsp_valid = 1'b1;
            bus.dc_rsp_data  = word;
            @(negedge clk);
            chk("rsp_wb_early", 32'(bus.wb_valid), 32'd0);
            tick();
            bus.dc_rsp_valid = 1'b0;
            bus.dc_rsp_data  = $urandom;
        end

        @(negedge clk);
        chk("wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("wb_misalign", 32'(bus.wb_misalign), 32'(mis));
        chk("wb_data", bus.wb_data, exp_data);
        chk("wb_tag", 32'(bus.wb_rob_tag), 32'(tag));
        chk("wb_prd", 32'(bus.wb_prd), 32'(prd));
        chk("wb_no_req", 32'(bus.dc_req), 32'd0);
        chk("wb_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        @(negedge clk);
        chk("wb_pulse", 32'(bus.wb_valid), 32'd0);
        chk("wb_hold", bus.wb_data, exp_data);
        last_wb_data = exp_data;
        tick();
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        last_wb_data     = 32'd0;
        rst_n            = 1'b0;
        bus.flush        = 1'b0;
        bus.lsu_valid    = 1'b0;
        bus.lsu_addr     = 32'd0;
        bus.lsu_size     = 2'd0;
        bus.lsu_unsigned = 1'b0;
        bus.lsu_rob_tag  = 5'd0;
        bus.lsu_prd      = 6'd0;
        bus.dc_gnt       = 1'b0;
        bus.dc_rsp_valid = 1'b0;
        bus.dc_rsp_data  = 32'd0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_mis", 32'(bus.wb_misalign), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_tag", 32'(bus.wb_rob_tag), 32'd0);
        chk("rst_wb_prd", 32'(bus.wb_prd), 32'd0);
        chk("rst_dc_req", 32'(bus.dc_req), 32'd0);
        chk("rst_dc_addr", bus.dc_addr, 32'd0);
        chk("rst_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Aligned word, immediate grant and response
        do_load(32'h0000_1000, 2'd2, 1'b0, 5'h0A, 6'h15, 32'hDEAD_BEEF, 0, 0);
        // Signed byte in top lane, unsigned half in upper half
        do_load(32'h0000_1003, 2'd0, 1'b0, 5'h03, 6'h21, 32'h80FF_0000, 0, 0);
        do_load(32'h0000_1002, 2'd1, 1'b1, 5'h04, 6'h22, 32'h80FF_0000, 0, 0);
        // Misaligned word
        do_load(32'h0000_1002, 2'd2, 1'b0, 5'h05, 6'h23, 32'h0, 0, 0);
        // Grant stalled 4 cycles
        do_load(32'h0000_2004, 2'd2, 1'b0, 5'h06, 6'h24, 32'h1234_5678, 4, 1);

        // Flush in WAIT, response two cycles later
        present(32'h0000_3000, 2'd2, 1'b0, 5'h07, 6'h25);
        tick();
        bus.lsu_valid = 1'b0;
        bus.dc_gnt    = 1'b1;
        tick();
        bus.dc_gnt = 1'b0;
        bus.flush  = 1'b1;
        @(negedge clk);
        chk("fw_ready_flush", 32'(bus.lsu_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fw_drain_ready", 32'(bus.lsu_ready), 32'd0);
        chk("fw_drain_req", 32'(bus.dc_req), 32'd0);
        tick();
        bus.dc_rsp_valid = 1'b1;
        bus.dc_rsp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        chk("fw_rsp_ready", 32'(bus.lsu_ready), 32'd0);
        tick();
        bus.dc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fw_after_ready", 32'(bus.lsu_ready), 32'd1);
        chk("fw_after_wb", 32'(bus.wb_valid), 32'd0);
        chk("fw_after_data", bus.wb_data, last_wb_data);
        tick();

        // Flush coincident with the response
        present(32'h0000_3004, 2'd2, 1'b0, 5'h08, 6'h26);
        tick();
        bus.lsu_valid = 1'b0;
        bus.dc_gnt    = 1'b1;
        tick();
        bus.dc_gnt       = 1'b0;
        bus.flush        = 1'b1;
        bus.dc_rsp_valid = 1'b1;
        tick();
        bus.flush        = 1'b0;
        bus.dc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fr_wb", 32'(bus.wb_valid), 32'd0);
        chk("fr_ready", 32'(bus.lsu_ready), 32'd1);
        tick();

        // Flush in REQ without grant
        present(32'h0000_3008, 2'd2, 1'b0, 5'h09, 6'h27);
        tick();
        bus.lsu_valid = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clk);
        chk("fq_req_before", 32'(bus.dc_req), 32'd1);
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fq_req_drop", 32'(bus.dc_req), 32'd0);
        chk("fq_ready", 32'(bus.lsu_ready), 32'd1);
        tick();

        // Flush in REQ together with grant goes to DRAIN
        present(32'h0000_300C, 2'd2, 1'b0, 5'h0B, 6'h28);
        tick();
        bus.lsu_valid = 1'b0;
        bus.flush     = 1'b1;
        bus.dc_gnt    = 1'b1;
        tick();
        bus.flush  = 1'b0;
        bus.dc_gnt = 1'b0;
        @(negedge clk);
        chk("fg_drain_ready", 32'(bus.lsu_ready), 32'd0);
        tick();
        bus.dc_rsp_valid = 1'b1;
        tick();
        bus.dc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fg_wb", 32'(bus.wb_valid), 32'd0);
        chk("fg_ready", 32'(bus.lsu_ready), 32'd1);
        tick();

        // Flush beats a simultaneous misaligned packet in IDLE
        present(32'h0000_1001, 2'd2, 1'b0, 5'h0C, 6'h29);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fi_ready", 32'(bus.lsu_ready), 32'd0);
        tick();
        bus.lsu_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk("fi_wb", 32'(bus.wb_valid), 32'd0);
        chk("fi_req", 32'(bus.dc_req), 32'd0);
        tick();

        // Stray response in IDLE
        bus.dc_rsp_valid = 1'b1;
        tick();
        bus.dc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stray_wb", 32'(bus.wb_valid), 32'd0);
        chk("stray_data", bus.wb_data, last_wb_data);
        tick();

        // Reset mid-WAIT followed by a stray response
        present(32'h0000_4000, 2'd2, 1'b0, 5'h1F, 6'h3F);
        tick();
        bus.lsu_valid = 1'b0;
        bus.dc_gnt    = 1'b1;
        tick();
        bus.dc_gnt = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n            = 1'b1;
        bus.dc_rsp_valid = 1'b1;
        bus.dc_rsp_data  = 32'h5555_AAAA;
        @(negedge clk);
        chk("mr_wb", 32'(bus.wb_valid), 32'd0);
        chk("mr_data", bus.wb_data, 32'd0);
        chk("mr_tag", 32'(bus.wb_rob_tag), 32'd0);
        chk("mr_prd", 32'(bus.wb_prd), 32'd0);
        chk("mr_mis", 32'(bus.wb_misalign), 32'd0);
        chk("mr_req", 32'(bus.dc_req), 32'd0);
        chk("mr_addr", bus.dc_addr, 32'd0);
        chk("mr_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        bus.dc_rsp_valid = 1'b0;
        @(negedge clk);
        chk("mr_stray_wb", 32'(bus.wb_valid), 32'd0);
        tick();

        // Randomized loads, all sizes and offsets including illegal size 3
        for (int n = 0; n < 60; n++) begin
            do_load($urandom, 2'($urandom_range(3)), 1'($urandom_range(1)),
                    5'($urandom_range(31)), 6'($urandom_range(63)), $urandom,
                    int'($urandom_range(3)), int'($urandom_range(3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
